// File: rtl/ctrl_word_sequencer_pkg.sv
// ctrl_word_sequencer_pkg: shared sizes, state encoding and step-count helper
package ctrl_word_sequencer_pkg;
  localparam int WIDTH   = 15;
  localparam int DEPTH   = 8;
  localparam int DWELL_W = 16;
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int STEPS_W = 4;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  function automatic logic [STEPS_W-1:0] eff_steps(input logic [STEPS_W-1:0] n);
    return (n > STEPS_W'(DEPTH)) ? STEPS_W'(DEPTH) : n;
  endfunction
endpackage

// File: rtl/ctrl_word_sequencer_if.sv
// ctrl_word_sequencer_if: config, control and status signals of the sequencer
interface ctrl_word_sequencer_if;
  import ctrl_word_sequencer_pkg::*;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_addr;
  logic [WIDTH-1:0]   cfg_word;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [STEPS_W-1:0] num_steps;
  logic               loop;
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   idle_word;
  logic [WIDTH-1:0]   ctrl_word;
  logic [IDX_W-1:0]   step_idx;
  logic               step_strobe;
  logic               busy;
  logic               done;
  modport master (
    output cfg_we, cfg_addr, cfg_word, cfg_dwell, num_steps, loop, start, abort, idle_word,
    input  ctrl_word, step_idx, step_strobe, busy, done
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_word, cfg_dwell, num_steps, loop, start, abort, idle_word,
    output ctrl_word, step_idx, step_strobe, busy, done
  );
endinterface

// File: rtl/ctrl_word_sequencer_seq_table.sv
// seq_table: step table of control words and dwells, one write port, one async read port
module seq_table
  import ctrl_word_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_we,
  input  logic [IDX_W-1:0]   i_waddr,
  input  logic [WIDTH-1:0]   i_wword,
  input  logic [DWELL_W-1:0] i_wdwell,
  input  logic [IDX_W-1:0]   i_raddr,
  output logic [WIDTH-1:0]   o_rword,
  output logic [DWELL_W-1:0] o_rdwell
);
  logic [WIDTH-1:0]   r_word  [DEPTH];
  logic [DWELL_W-1:0] r_dwell [DEPTH];
  // table write; reset clears every entry
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_word[i]  <= '0;
        r_dwell[i] <= '0;
      end
    end else if (i_we) begin
      r_word[i_waddr]  <= i_wword;
      r_dwell[i_waddr] <= i_wdwell;
    end
  assign o_rword  = r_word[i_raddr];
  assign o_rdwell = r_dwell[i_raddr];
endmodule

// File: rtl/ctrl_word_sequencer.sv
// ctrl_word_sequencer: steps a control word through a table with per-step dwell
module ctrl_word_sequencer
  import ctrl_word_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  ctrl_word_sequencer_if.slave bus
);
  state_t             r_state, w_state_nxt;
  logic [DWELL_W-1:0] r_cnt;
  logic [STEPS_W-1:0] r_eff;
  logic               r_loop;
  logic [IDX_W-1:0]   r_idx, w_next_idx;
  logic [WIDTH-1:0]   r_ctrl, w_rword;
  logic [DWELL_W-1:0] w_rdwell;
  logic               r_strobe, r_busy, r_done;
  logic               w_load, w_done, w_last, w_final;

  seq_table u_table (
    .clk      (clk),
    .resetn   (resetn),
    .i_we     (bus.cfg_we),
    .i_waddr  (bus.cfg_addr),
    .i_wword  (bus.cfg_word),
    .i_wdwell (bus.cfg_dwell),
    .i_raddr  (w_next_idx),
    .o_rword  (w_rword),
    .o_rdwell (w_rdwell)
  );

  // a dwell of 0 or 1 both make the current cycle the last of the step
  assign w_last  = r_cnt <= DWELL_W'(1);
  assign w_final = STEPS_W'(r_idx) == r_eff - STEPS_W'(1);

  // next state, step-entry load and completion decision; abort outranks advance/done
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_next_idx  = '0;
    w_done      = 1'b0;
    if (r_state == IDLE) begin
      if (bus.start && !bus.abort && bus.num_steps != '0) begin
        w_state_nxt = RUN;
        w_load      = 1'b1;
      end
    end else if (bus.abort) begin
      w_state_nxt = IDLE;
    end else if (w_last) begin
      if (!w_final) begin
        w_load     = 1'b1;
        w_next_idx = r_idx + IDX_W'(1);
      end else if (r_loop) begin
        w_load = 1'b1;
      end else begin
        w_state_nxt = IDLE;
        w_done      = 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;

  // output, dwell counter and latched sequence parameters
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_ctrl   <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_eff    <= '0;
      r_loop   <= 1'b0;
    end else begin
      r_ctrl   <= w_load ? w_rword : (w_state_nxt == IDLE ? bus.idle_word : r_ctrl);
      r_idx    <= w_load ? w_next_idx : (w_state_nxt == IDLE ? '0 : r_idx);
      r_cnt    <= w_load ? w_rdwell : (r_cnt != '0 ? r_cnt - DWELL_W'(1) : '0);
      r_strobe <= w_load;
      r_busy   <= w_state_nxt == RUN;
      r_done   <= w_done;
      if (r_state == IDLE && w_load) begin
        r_eff  <= eff_steps(bus.num_steps);
        r_loop <= bus.loop;
      end
    end

  assign bus.ctrl_word   = r_ctrl;
  assign bus.step_idx    = r_idx;
  assign bus.step_strobe = r_strobe;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
endmodule

// File: tb/tb_ctrl_word_sequencer.sv
// tb_ctrl_word_sequencer: directed + random stimulus against a behavioural sequence model
module tb_ctrl_word_sequencer;
  import ctrl_word_sequencer_pkg::*;
  logic clk, resetn;
  ctrl_word_sequencer_if bus ();
  ctrl_word_sequencer dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int n_strobe, n_busy, n_done;

  int m_tw [DEPTH];
  int m_td [DEPTH];
  bit m_run, m_loop;
  int m_idx, m_rem, m_eff;
  int e_ctrl, e_idx, e_strobe, e_busy, e_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin m_tw[i] = 0; m_td[i] = 0; end
    m_run = 0; m_loop = 0; m_idx = 0; m_rem = 0; m_eff = 0;
    e_ctrl = 0; e_idx = 0; e_strobe = 0; e_busy = 0; e_done = 0;
  endtask

  task automatic enter(input int i);
    m_run = 1; m_idx = i;
    m_rem = (m_td[i] == 0) ? 1 : m_td[i];
    e_ctrl = m_tw[i]; e_idx = i; e_strobe = 1;
  endtask

  task automatic go_idle(input bit fin);
    m_run = 0; e_ctrl = int'(bus.idle_word); e_idx = 0; e_done = int'(fin);
  endtask

  task automatic model_step();
    e_strobe = 0; e_done = 0;
    if (!m_run) begin
      if (bus.start && !bus.abort && bus.num_steps != 0) begin
        m_eff  = (bus.num_steps > DEPTH) ? DEPTH : int'(bus.num_steps);
        m_loop = bus.loop;
        enter(0);
      end else go_idle(0);
    end else if (bus.abort) go_idle(0);
    else if (m_rem > 1) m_rem--;
    else if (m_idx + 1 < m_eff) enter(m_idx + 1);
    else if (m_loop) enter(0);
    else go_idle(1);
    e_busy = int'(m_run);
    if (bus.cfg_we) begin
      m_tw[bus.cfg_addr] = int'(bus.cfg_word);
      m_td[bus.cfg_addr] = int'(bus.cfg_dwell);
    end
  endtask

  task automatic compare_all();
    check("ctrl_word", 32'(bus.ctrl_word), e_ctrl);
    check("step_idx", 32'(bus.step_idx), e_idx);
    check("step_strobe", 32'(bus.step_strobe), e_strobe);
    check("busy", 32'(bus.busy), e_busy);
    check("done", 32'(bus.done), e_done);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    n_strobe += int'(bus.step_strobe);
    n_busy   += int'(bus.busy);
    n_done   += int'(bus.done);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input int a, input int w, input int d);
    bus.cfg_we = 1; bus.cfg_addr = IDX_W'(a); bus.cfg_word = WIDTH'(w); bus.cfg_dwell = DWELL_W'(d);
    cycle();
    bus.cfg_we = 0;
  endtask

  task automatic pulse_start(input int steps, input bit lp);
    bus.num_steps = STEPS_W'(steps); bus.loop = lp; bus.start = 1;
    cycle();
    bus.start = 0;
  endtask

  task automatic clr_stats();
    n_strobe = 0; n_busy = 0; n_done = 0;
  endtask

  initial begin
    bit saw;
    resetn = 0;
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_word = 0; bus.cfg_dwell = 0;
    bus.num_steps = 0; bus.loop = 0; bus.start = 0; bus.abort = 0; bus.idle_word = 0;
    model_reset();
    clr_stats();
    #12;
    compare_all();
    @(negedge clk) resetn = 1;
    bus.idle_word = 15'h0AAA;

    // one-shot three-step sequence
    wr(0, 16'h0001, 3);
    wr(1, 16'h4000, 1);
    wr(2, 16'h7FFF, 2);
    run(2);
    clr_stats();
    pulse_start(3, 0);
    run(9);
    check("t1_strobes", n_strobe, 3);
    check("t1_busy_cycles", n_busy, 6);
    check("t1_done_pulses", n_done, 1);

    // looped sequence then abort
    clr_stats();
    pulse_start(3, 1);
    run(12);
    check("t2_no_done", n_done, 0);
    bus.abort = 1;
    cycle();
    bus.abort = 0;
    check("t2_abort_busy", 32'(bus.busy), 0);
    check("t2_abort_word", 32'(bus.ctrl_word), 32'h0AAA);
    run(2);

    // zero dwell single step, then zero steps
    wr(0, 16'h0555, 0);
    clr_stats();
    pulse_start(1, 0);
    run(3);
    check("t3_busy_one", n_busy, 1);
    clr_stats();
    pulse_start(0, 0);
    run(3);
    check("t3_zero_busy", n_busy, 0);
    check("t3_zero_strobe", n_strobe, 0);

    // table write during RUN and restart attempt
    wr(0, 16'h0001, 3);
    pulse_start(3, 1);
    run(3);
    check("t4_in_step1", 32'(bus.step_idx), 1);
    bus.start = 1;
    wr(0, 16'h1234, 2);
    bus.start = 0;
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (bus.step_strobe && bus.step_idx == 0 && bus.ctrl_word == 15'h1234) saw = 1;
    end
    check("t4_wrap_new_word", 32'(saw), 1);
    bus.abort = 1; cycle(); bus.abort = 0;

    // async reset during step 2
    pulse_start(3, 0);
    for (int i = 0; i < 20 && m_idx != 2; i++) cycle();
    check("t5_reach_step2", m_idx, 2);
    #2 resetn = 0;
    #1;
    model_reset();
    check("t5_async_word", 32'(bus.ctrl_word), 0);
    check("t5_async_busy", 32'(bus.busy), 0);
    compare_all();
    @(negedge clk) resetn = 1;
    clr_stats();
    pulse_start(3, 0);
    check("t5_cleared_word", 32'(bus.ctrl_word), 0);
    run(4);
    check("t5_done_after", n_done, 1);
    bus.start = 1; bus.abort = 1; bus.num_steps = 3;
    cycle();
    bus.start = 0; bus.abort = 0;
    check("t5_start_abort", 32'(bus.busy), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.start     = ($urandom_range(7) == 0);
      bus.abort     = ($urandom_range(40) == 0);
      bus.cfg_we    = ($urandom_range(3) == 0);
      bus.cfg_addr  = IDX_W'($urandom);
      bus.cfg_word  = WIDTH'($urandom);
      bus.cfg_dwell = DWELL_W'($urandom_range(4));
      bus.num_steps = STEPS_W'($urandom_range(15));
      bus.loop      = ($urandom_range(3) == 0);
      bus.idle_word = WIDTH'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
